// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - instruction fetch unit: program counter plus two-byte instruction fetch
package cpu_common;
    typedef enum logic [1:0] {
        FETCH_NOP    = 2'd0,
        FETCH_INC_PC = 2'd1,
        FETCH_RET    = 2'd2
    } fetch_operation_t;
endpackage

module cpu_fetch #(
    parameter int PC_WIDTH = 13
) (
    input  logic                         clk,
    input  logic                         rst,
    input  cpu_common::fetch_operation_t fetch_op_i,
    input  logic [PC_WIDTH-1:0]          ret_addr_i,
    output logic [PC_WIDTH-1:0]          mem_addr_o,
    output logic                         mem_rd_o,
    input  logic                         mem_gnt_i,
    input  logic [7:0]                   mem_data_i,
    output logic [15:0]                  inst_o,
    output logic                         inst_valid_o,
    output logic [PC_WIDTH-1:0]          pc_o
);
    typedef enum logic [2:0] {
        S_REQ_LO = 3'd0,
        S_CAP_LO = 3'd1,
        S_REQ_HI = 3'd2,
        S_CAP_HI = 3'd3,
        S_READY  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [15:0]         r_inst;
    logic [PC_WIDTH-1:0] w_pc_plus1;
    logic [PC_WIDTH-1:0] w_pc_plus2;
    logic                w_accept;

    // Address arithmetic wraps naturally at the PC width.
    assign w_pc_plus1 = r_pc + PC_WIDTH'(1);
    assign w_pc_plus2 = r_pc + PC_WIDTH'(2);
    assign w_accept   = (fetch_op_i == cpu_common::FETCH_INC_PC) ||
                        (fetch_op_i == cpu_common::FETCH_RET);

    assign inst_o = r_inst;
    assign pc_o   = r_pc;

    // State register; reset restarts the fetch at REQ_LO from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ_LO;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: byte capture, pc advance after the high byte, pc load on return.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= '0;
            r_inst <= '0;
        end else begin
            case (r_state)
                S_CAP_LO: r_inst[7:0] <= mem_data_i;
                S_CAP_HI: begin
                    r_inst[15:8] <= mem_data_i;
                    r_pc         <= w_pc_plus2;
                end
                S_READY: begin
                    if (fetch_op_i == cpu_common::FETCH_RET) begin
                        r_pc <= ret_addr_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and state-decoded memory/valid outputs, forced quiet during reset.
    always_comb begin
        w_next_state = r_state;
        mem_rd_o     = 1'b0;
        mem_addr_o   = '0;
        inst_valid_o = 1'b0;
        case (r_state)
            S_REQ_LO: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = r_pc;
                if (mem_gnt_i) begin
                    w_next_state = S_CAP_LO;
                end
            end
            S_CAP_LO: w_next_state = S_REQ_HI;
            S_REQ_HI: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = w_pc_plus1;
                if (mem_gnt_i) begin
                    w_next_state = S_CAP_HI;
                end
            end
            S_CAP_HI: w_next_state = S_READY;
            S_READY: begin
                inst_valid_o = 1'b1;
                if (w_accept) begin
                    w_next_state = S_REQ_LO;
                end
            end
            default: w_next_state = S_REQ_LO;
        endcase
        if (rst) begin
            mem_rd_o     = 1'b0;
            mem_addr_o   = '0;
            inst_valid_o = 1'b0;
        end
    end
endmodule

// File: tb/tb_cpu_fetch.sv
// tb/tb_cpu_fetch.sv - self-checking bench for cpu_fetch
module tb_cpu_fetch;
    localparam int PW = 13;

    logic                         clk;
    logic                         rst;
    cpu_common::fetch_operation_t fetch_op_i;
    logic [PW-1:0]                ret_addr_i;
    logic [PW-1:0]                mem_addr_o;
    logic                         mem_rd_o;
    logic                         mem_gnt_i;
    logic [7:0]                   mem_data_i;
    logic [15:0]                  inst_o;
    logic                         inst_valid_o;
    logic [PW-1:0]                pc_o;

    int errors = 0;
    int checks = 0;

    logic [7:0]    mem [0:(1<<PW)-1];
    logic [PW-1:0] exp_addr_q [$];
    logic [15:0]   exp_inst_q [$];
    logic [PW-1:0] exp_pc_q   [$];
    logic          prev_valid = 1'b0;

    cpu_fetch #(.PC_WIDTH(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_op_i   (fetch_op_i),
        .ret_addr_i   (ret_addr_i),
        .mem_addr_o   (mem_addr_o),
        .mem_rd_o     (mem_rd_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_data_i   (mem_data_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .pc_o         (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory: data follows a granted request by one cycle, otherwise garbage.
    always @(posedge clk) begin
        if (mem_rd_o && mem_gnt_i) mem_data_i <= mem[mem_addr_o];
        else                       mem_data_i <= 8'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every granted read and every new valid instruction is matched against the queues.
    always @(negedge clk) begin
        if (!rst && mem_rd_o && mem_gnt_i) begin
            chk("read_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) chk("read_addr", 32'(mem_addr_o), 32'(exp_addr_q.pop_front()));
        end
        if (inst_valid_o === 1'b1 && prev_valid !== 1'b1) begin
            chk("inst_expected", 32'(exp_inst_q.size() != 0), 32'd1);
            if (exp_inst_q.size() != 0) begin
                chk("sb_inst", 32'(inst_o), 32'(exp_inst_q.pop_front()));
                chk("sb_pc", 32'(pc_o), 32'(exp_pc_q.pop_front()));
            end
        end
        prev_valid = inst_valid_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (inst_valid_o !== 1'b1 && n < 40);
    endtask

    initial begin
        int n;
        for (int i = 0; i < (1 << PW); i++) mem[i] = 8'($urandom);
        mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'hCD; mem[3] = 8'hAB;
        mem[4] = 8'hEF; mem[5] = 8'hBE; mem[13'h1FFF] = 8'h78;
        rst = 1'b1; mem_gnt_i = 1'b1;
        fetch_op_i = cpu_common::FETCH_NOP; ret_addr_i = '0;

        // Reset state
        tick(); tick();
        chk("rst_rd", 32'(mem_rd_o), 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", 32'(inst_o), 32'd0);
        chk("rst_pc", 32'(pc_o), 32'd0);

        // Reset fetch with exact cycle timing
        exp_addr_q.push_back(13'd0); exp_addr_q.push_back(13'd1);
        exp_inst_q.push_back(16'h1234); exp_pc_q.push_back(13'd2);
        rst = 1'b0; #1;
        chk("c0_rd", 32'(mem_rd_o), 32'd1);
        chk("c0_addr", 32'(mem_addr_o), 32'd0);
        tick();
        chk("c1_rd", 32'(mem_rd_o), 32'd0);
        tick();
        chk("c2_rd", 32'(mem_rd_o), 32'd1);
        chk("c2_addr", 32'(mem_addr_o), 32'd1);
        tick();
        chk("c3_valid", 32'(inst_valid_o), 32'd0);
        tick();
        chk("c4_valid", 32'(inst_valid_o), 32'd1);
        chk("c4_inst", 32'(inst_o), 32'h1234);
        chk("c4_pc", 32'(pc_o), 32'd2);

        // NOP hold
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("nop_rd", 32'(mem_rd_o), 32'd0);
            chk("nop_valid", 32'(inst_valid_o), 32'd1);
            chk("nop_inst", 32'(inst_o), 32'h1234);
            chk("nop_pc", 32'(pc_o), 32'd2);
        end

        // Sequential fetch
        exp_addr_q.push_back(13'd2); exp_addr_q.push_back(13'd3);
        exp_inst_q.push_back(16'hABCD); exp_pc_q.push_back(13'd4);
        fetch_op_i = cpu_common::FETCH_INC_PC;
        tick();
        fetch_op_i = cpu_common::FETCH_NOP;
        chk("inc_valid_drop", 32'(inst_valid_o), 32'd0);
        wait_valid(n);
        chk("inc_latency", 32'(n), 32'd4);
        chk("inc_inst", 32'(inst_o), 32'hABCD);
        chk("inc_pc", 32'(pc_o), 32'd4);

        // Grant stall in REQ_HI
        exp_addr_q.push_back(13'd4); exp_addr_q.push_back(13'd5);
        exp_inst_q.push_back(16'hBEEF); exp_pc_q.push_back(13'd6);
        fetch_op_i = cpu_common::FETCH_INC_PC;
        tick();
        fetch_op_i = cpu_common::FETCH_NOP;
        n = 0;
        while (inst_valid_o !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (n >= 2 && n <= 4) begin
                mem_gnt_i = 1'b0;
                #1;
                chk("stall_rd", 32'(mem_rd_o), 32'd1);
                chk("stall_addr", 32'(mem_addr_o), 32'd5);
            end else begin
                mem_gnt_i = 1'b1;
            end
        end
        mem_gnt_i = 1'b1;
        chk("stall_latency", 32'(n), 32'd7);
        chk("stall_inst", 32'(inst_o), 32'hBEEF);

        // Return with wrap-around
        mem[0] = 8'h56;
        exp_addr_q.push_back(13'h1FFF); exp_addr_q.push_back(13'h0000);
        exp_inst_q.push_back(16'h5678); exp_pc_q.push_back(13'h0001);
        ret_addr_i = 13'h1FFF;
        fetch_op_i = cpu_common::FETCH_RET;
        tick();
        fetch_op_i = cpu_common::FETCH_NOP;
        ret_addr_i = '0;
        chk("ret_pc_load", 32'(pc_o), 32'h1FFF);
        chk("ret_valid_drop", 32'(inst_valid_o), 32'd0);
        wait_valid(n);
        chk("ret_latency", 32'(n), 32'd4);
        chk("ret_inst", 32'(inst_o), 32'h5678);
        chk("ret_pc", 32'(pc_o), 32'h0001);

        // Reset while in CAP_HI
        exp_addr_q.push_back(13'd1); exp_addr_q.push_back(13'd2);
        fetch_op_i = cpu_common::FETCH_INC_PC;
        tick();
        fetch_op_i = cpu_common::FETCH_NOP;
        tick(); tick(); tick();
        rst = 1'b1; #1;
        chk("mid_rst_rd", 32'(mem_rd_o), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr_o), 32'd0);
        tick();
        chk("mid_rst_valid", 32'(inst_valid_o), 32'd0);
        chk("mid_rst_inst", 32'(inst_o), 32'd0);
        chk("mid_rst_pc", 32'(pc_o), 32'd0);
        exp_addr_q.push_back(13'd0); exp_addr_q.push_back(13'd1);
        exp_inst_q.push_back(16'h1256); exp_pc_q.push_back(13'd2);
        rst = 1'b0; #1;
        chk("restart_addr", 32'(mem_addr_o), 32'd0);
        chk("restart_rd", 32'(mem_rd_o), 32'd1);
        wait_valid(n);
        chk("restart_latency", 32'(n), 32'd4);
        chk("restart_pc", 32'(pc_o), 32'd2);
        tick(); tick();

        chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        chk("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_fetch.md
# cpu_fetch

Instruction fetch unit for the vgacpu core. It owns the program counter and reads 16-bit instructions as two bytes, low byte first, from byte-wide shared memory. It holds the fetched instruction for the control unit. It consumes the `cpu_common::fetch_operation_t` commands that the control unit issues: `FETCH_NOP`, `FETCH_INC_PC` and `FETCH_RET`.

## Interface

Parameters:
- `PC_WIDTH`, default 13: program counter and memory address width in bits (8 KiB space).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_op_i`  in  `cpu_common::fetch_operation_t`  command from control. Sampled only in READY.
- `ret_addr_i`  in  PC_WIDTH  return address popped from the stack. Sampled with `FETCH_RET`.
- `mem_addr_o`  out  PC_WIDTH  byte address for the memory read.
- `mem_rd_o`  out  1  read request.
- `mem_gnt_i`  in  1  arbiter grant. Request and address must hold until granted.
- `mem_data_i`  in  8  read data, valid the cycle after a granted request.
- `inst_o`  out  16  current instruction, `{hi_byte, lo_byte}`.
- `inst_valid_o`  out  1  `inst_o` is complete and the unit is in READY.
- `pc_o`  out  PC_WIDTH  address of the byte following the current instruction (the call push value).

## Operation

- FSM states: REQ_LO, CAP_LO, REQ_HI, CAP_HI, READY.
- **REQ_LO**
  - `mem_rd_o`=1, `mem_addr_o`=`pc`.
  - If `mem_gnt_i`, go to CAP_LO. Otherwise stay, with address and request unchanged.
- **CAP_LO**
  - `mem_rd_o`=0.
  - `inst_o[7:0]` <= `mem_data_i`.
  - Go to REQ_HI.
- **REQ_HI**
  - `mem_rd_o`=1, `mem_addr_o`=`pc+1` (mod 2^PC_WIDTH).
  - If granted, go to CAP_HI. Otherwise stay.
- **CAP_HI**
  - `inst_o[15:8]` <= `mem_data_i`.
  - `pc` <= `pc+2` (mod 2^PC_WIDTH).
  - Go to READY.
- **READY**
  - `inst_valid_o`=1, `mem_rd_o`=0.
  - `FETCH_NOP`: stay; `pc` and `inst_o` are unchanged.
  - `FETCH_INC_PC`: go to REQ_LO. `pc` already points at the next instruction.
  - `FETCH_RET`: `pc` <= `ret_addr_i`, go to REQ_LO.
- `fetch_op_i` is ignored in every state other than READY.
- Data is captured only in CAP_LO and CAP_HI. `mem_data_i` in any other cycle is don't-care.
- `inst_o` is partially updated mid-fetch and is meaningful only while `inst_valid_o`=1.
- No alignment is required. Odd `pc` and odd `ret_addr_i` are legal.
- Wrap-around: the byte after address 2^PC_WIDTH-1 is address 0. The same rule applies to `pc+2`.
- Reset:
  - Applies in any state, including mid-fetch. It overrides any command on the same edge.
  - State becomes REQ_LO, `pc`=0, `inst_o`=0.
  - `mem_rd_o`, `inst_valid_o` and `mem_addr_o` are 0 while `rst`=1.
- Outputs `mem_rd_o`, `mem_addr_o` and `inst_valid_o` are decoded from state; `inst_o` and `pc_o` are registers.

## Timing

- With grant always high, an instruction is ready 4 cycles after fetch starts. Counting from the first cycle with `rst`=0 as cycle 0:
  - Cycle 0: request at `pc`.
  - Cycle 1: low byte captured.
  - Cycle 2: request at `pc+1`.
  - Cycle 3: high byte captured.
  - Cycle 4: `inst_valid_o`=1.
- Each cycle of withheld grant adds one cycle in REQ_LO or REQ_HI.
- After a command is accepted in READY, `inst_valid_o` falls on the next cycle.
- The next `inst_valid_o` arrives 4 cycles after acceptance, plus any grant stalls.
- `pc_o` is updated on the CAP_HI edge, so it is stable for the whole READY period.
- After `FETCH_RET`, `pc_o` shows `ret_addr_i` from the next cycle until CAP_HI.

## Test plan

- **Reset fetch.** Memory holds [0]=0x34, [1]=0x12; grant tied to 1; release reset.
  - Response: `mem_rd_o` at addr 0 in cycle 0 and at addr 1 in cycle 2.
  - Cycle 4: `inst_valid_o`=1, `inst_o`=0x1234, `pc_o`=2.
- **NOP hold.** Hold `FETCH_NOP` for 10 cycles in READY.
  - Response: `mem_rd_o` stays 0; `inst_o`=0x1234 and `pc_o`=2 are stable.
- **Sequential fetch.** Memory holds [2]=0xCD, [3]=0xAB; issue `FETCH_INC_PC`.
  - Response: `inst_valid_o`=0 next cycle; reads at 2 then 3.
  - `inst_o`=0xABCD and `pc_o`=4, four cycles after acceptance.
- **Grant stall.** Drop `mem_gnt_i` for 3 cycles while in REQ_HI.
  - Response: `mem_addr_o`=`pc+1` and `mem_rd_o`=1 held through the stall.
  - `inst_valid_o` arrives 7 cycles after acceptance, with the correct instruction.
- **Return with wrap.** With PC_WIDTH=13, memory [0x1FFF]=0x78, [0x0000]=0x56; issue `FETCH_RET` with `ret_addr_i`=0x1FFF.
  - Response: reads at 0x1FFF then 0x0000.
  - `inst_o`=0x5678, `pc_o`=0x0001.
- **Reset mid-fetch.** Assert `rst` for 1 cycle while in CAP_HI.
  - Response: `inst_valid_o`=0, `inst_o`=0, `pc_o`=0.
  - Fetch restarts at address 0, and the interrupted `pc+2` update never occurs.
